// File: rtl/memory_io_responder_pkg.sv
// Shared types and constants for the memory_io responder.
// memory_io_req / memory_io_rsp mirror the existing memory_io struct layout.
package memory_io_responder_pkg;

  localparam int LAT_W     = 4;  // latency counter width, covers LATENCY 1..15
  localparam int NUM_LANES = 4;  // byte lanes per 32-bit word

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } rsp_state_e;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          addr;
    logic [NUM_LANES-1:0] do_read;
    logic [NUM_LANES-1:0] do_write;
    logic [31:0]          data;
  } memory_io_req;

  typedef struct packed {
    logic        ready;
    logic        valid;
    logic [31:0] data;
  } memory_io_rsp;

endpackage

// File: rtl/memory_io_responder_byte_mask_ram.sv
// Word-organised RAM with per-byte write enables. One storage array per lane;
// the registered read returns the contents from before a same-edge write.
module byte_mask_ram
  import memory_io_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 16384,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                          clk,
  input  logic                          en,
  input  logic [AW-1:0]                 addr,
  input  logic [NUM_LANES-1:0]          we,
  input  logic [NUM_LANES-1:0][7:0]     wdata,
  output logic [NUM_LANES-1:0][7:0]     rdata
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_q;

    // Read and conditional write on the same enabled edge; rd_q sees old data.
    always_ff @(posedge clk) begin
      if (en) begin
        rd_q <= mem[addr];
        if (we[i]) mem[addr] <= wdata[i];
      end
    end

    assign rdata[i] = rd_q;
  end

endmodule

// File: rtl/memory_io_responder.sv
// memory_io responder: one request at a time, byte-masked writes, masked read
// data returned LATENCY cycles after accept with a one-cycle rsp.valid pulse.
// Optional feature: define MEMORY_RESPONDER_STATS_EN for read/write counters.
module memory_io_responder
  import memory_io_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 16384,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic         clk,
  input  logic         reset,
  input  memory_io_req req,
  output memory_io_rsp rsp
`ifdef MEMORY_RESPONDER_STATS_EN
  ,
  output logic [31:0]  read_count,
  output logic [31:0]  write_count
`endif
);

  localparam int              AW     = $clog2(DEPTH_WORDS);
  localparam logic [LAT_W-1:0] LAT_M1 = LAT_W'(LATENCY - 1);

  rsp_state_e                    state;
  logic [LAT_W-1:0]              count;
  logic                          ready_q;
  logic                          valid_q;
  logic [NUM_LANES-1:0]          rd_mask_q;
  logic [NUM_LANES-1:0]          out_mask_q;
  logic [31:0]                   offset;
  logic [AW-1:0]                 word_addr;
  logic                          accept;
  logic [NUM_LANES-1:0][7:0]     wdata;
  logic [NUM_LANES-1:0][7:0]     rdata;
  logic                          unused_ok;

  // Addresses wrap modulo the depth; the byte offset bits are ignored.
  assign offset    = req.addr - BASE_ADDR;
  assign word_addr = offset[AW+1:2];
  assign unused_ok = ^{offset[1:0], offset[31:AW+2]};
  assign wdata     = req.data;

  // Reset has priority over an incoming request.
  assign accept = req.valid && ready_q && !reset;

  byte_mask_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk   (clk),
    .en    (accept),
    .addr  (word_addr),
    .we    (req.do_write),
    .wdata (wdata),
    .rdata (rdata)
  );

  // Request FSM with latency counter and registered response controls.
  // ready_q resets to 1 and is masked by reset at the output, so ready is low
  // during reset and high in the first cycle after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      rd_mask_q  <= '0;
      out_mask_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ready_q   <= 1'b0;
            rd_mask_q <= req.do_read;
            if (LATENCY == 1) begin
              state      <= RESPOND;
              valid_q    <= 1'b1;
              out_mask_q <= req.do_read;
            end else begin
              state <= WAIT;
              count <= LAT_M1;
            end
          end
        end
        WAIT: begin
          count <= count - 1'b1;
          if (count <= 1) begin
            state      <= RESPOND;
            valid_q    <= 1'b1;
            out_mask_q <= rd_mask_q;
          end
        end
        RESPOND: begin
          state      <= IDLE;
          valid_q    <= 1'b0;
          out_mask_q <= '0;
          ready_q    <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response: lanes not requested for read (and all lanes outside RESPOND) are 0.
  always_comb begin
    rsp       = '0;
    rsp.ready = ready_q && !reset;
    rsp.valid = valid_q;
    for (int i = 0; i < NUM_LANES; i++)
      if (out_mask_q[i]) rsp.data[8*i +: 8] = rdata[i];
  end

`ifdef MEMORY_RESPONDER_STATS_EN
  // Accepted-request counters; a combined read/write bumps both.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_count  <= '0;
      write_count <= '0;
    end else if (accept) begin
      if (|req.do_read)  read_count  <= read_count + 1'b1;
      if (|req.do_write) write_count <= write_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_io_responder.sv
// Scoreboard bench for memory_io_responder (DEPTH_WORDS=16, LATENCY=2).
module tb_memory_io_responder;
  import memory_io_responder_pkg::*;

  localparam int          DEPTH = 16;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  memory_io_req req;
  memory_io_rsp rsp;
`ifdef MEMORY_RESPONDER_STATS_EN
  logic [31:0]  read_count, write_count;
`endif

  always #5 clk = ~clk;

  memory_io_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .rsp   (rsp)
`ifdef MEMORY_RESPONDER_STATS_EN
    ,
    .read_count  (read_count),
    .write_count (write_count)
`endif
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // Reference model: word array plus expected-response queue.
  logic [31:0] model [DEPTH];
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q[$];
  int exp_rd = 0;
  int exp_wr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Issue one request; while not ready, drive junk (sometimes with valid) that must be ignored.
  task automatic issue(input logic [31:0] a, input logic [3:0] rd, input logic [3:0] wr,
                       input logic [31:0] d);
    bit          done = 0;
    int          guard = 0;
    logic        rdy;
    int          c0;
    logic [31:0] off;
    int          idx;
    logic [31:0] old, e;
    while (!done) begin
      @(negedge clk);
      req.valid = 1'b1; req.addr = a; req.do_read = rd; req.do_write = wr; req.data = d;
      #1;
      rdy = rsp.ready;
      c0  = cyc;
      if (rdy) begin
        @(posedge clk);
        off = (a - BASE) >> 2;
        idx = int'(off % DEPTH);
        old = model[idx];
        e   = '0;
        for (int i = 0; i < 4; i++) begin
          if (rd[i]) e[8*i +: 8] = old[8*i +: 8];
          if (wr[i]) model[idx][8*i +: 8] = d[8*i +: 8];
        end
        q.push_back('{e, c0 + LAT});
        if (|rd) exp_rd++;
        if (|wr) exp_wr++;
        done = 1;
      end else begin
        req.valid    = 1'($urandom_range(0, 1));
        req.addr     = $urandom;
        req.do_read  = 4'($urandom);
        req.do_write = 4'($urandom);
        req.data     = $urandom;
        guard++;
        if (guard > 50) begin
          chk("ready_timeout", 32'd0, 32'd1);
          done = 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req.valid = 1'b0;
    end
  endtask

  // Monitor: checks ready against model occupancy, and pops one expectation per valid pulse.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("ready", 32'(rsp.ready), 32'((q.size() == 0) && !reset));
      if (rsp.valid) begin
        if (q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_data", rsp.data, e.data);
          chk("latency", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        chk("idle_data", rsp.data, 32'd0);
      end
    end
  end

  initial begin
    int drain;
    req = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(3);

    // Fill every word so later reads are defined.
    for (int w = 0; w < DEPTH; w++) issue(32'(w * 4), 4'h0, 4'hF, $urandom);

    issue(32'h10, 4'h0, 4'hF, 32'hDEADBEEF);
    issue(32'h10, 4'hF, 4'h0, 32'h0);
    issue(32'h10, 4'h0, 4'b0010, 32'h0000AA00);
    issue(32'h10, 4'hF, 4'h0, 32'h0);
    issue(32'h10, 4'b0010, 4'h0, 32'h0);
    issue(32'h10, 4'hF, 4'hF, 32'h12345678);
    issue(32'h10, 4'hF, 4'h0, 32'h0);
    issue(32'h40, 4'h0, 4'hF, 32'hCAFEF00D);
    issue(32'h00, 4'hF, 4'h0, 32'h0);
    issue(32'h20, 4'h0, 4'h0, 32'hFFFFFFFF);
    idle(4);

    // Reset while a read is in WAIT; also offer a write during reset (must be dropped).
    issue(32'h10, 4'hF, 4'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    exp_rd = 0;
    exp_wr = 0;
    req.valid = 1'b1; req.addr = 32'h10; req.do_read = 4'h0; req.do_write = 4'hF;
    req.data = 32'hBAD0BAD0;
    @(negedge clk);
    reset = 1'b0;
    req.valid = 1'b0;
    issue(32'h10, 4'hF, 4'h0, 32'h0);
    issue(32'h00, 4'hF, 4'h0, 32'h0);

    // Randomized traffic with occasional gaps.
    for (int n = 0; n < 300; n++) begin
      issue($urandom, 4'($urandom), 4'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(1);
    drain = 0;
    while (q.size() != 0 && drain < 20) begin
      @(negedge clk);
      drain++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    idle(2);

`ifdef MEMORY_RESPONDER_STATS_EN
    chk("read_count", read_count, 32'(exp_rd));
    chk("write_count", write_count, 32'(exp_wr));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/memory_io_responder.md
# memory_io_responder

Single-port, word-organised memory that services the responder end of the memory_io request/response interface. It accepts one request at a time, commits byte-masked writes, returns read data after a fixed latency, and signals completion with a one-cycle response pulse. One instance sits behind a core's inst_mem_req/inst_mem_rsp pair and another behind its data_mem_req/data_mem_rsp pair, in both simulation and synthesis tops.

## Interface
- DEPTH_WORDS, 16384: number of 32-bit words stored (64 KiB); power of two.
- LATENCY, 2: cycles from request accept to response valid; legal range 1..15.
- BASE_ADDR, 32'h0: byte address that maps to word 0.
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- req  input  memory_io_req  request from the initiator. Fields used: valid, addr, do_read[3:0], do_write[3:0], data[31:0].
- rsp  output  memory_io_rsp  response to the initiator. Fields driven: ready, valid, data[31:0]. All other fields are tied to 0.
- read_count  output  32  reads accepted; present only with MEMORY_RESPONDER_STATS_EN.
- write_count  output  32  writes accepted; present only with MEMORY_RESPONDER_STATS_EN.

## Operation
- **Address mapping:**
  - Word index = ((addr − BASE_ADDR) >> 2) mod DEPTH_WORDS.
  - Out-of-range addresses wrap; they are never trapped.
  - addr[1:0] is ignored; lane selection comes only from the masks.
- **States:** IDLE, WAIT, RESPOND.
- **IDLE:**
  - rsp.ready = 1.
  - If req.valid is high at a rising edge, the request is accepted on that edge. The state moves to WAIT with count = LATENCY−1, or to RESPOND directly if LATENCY = 1.
- **WAIT:**
  - rsp.ready = 0.
  - The counter decrements each cycle; at 0 the state moves to RESPOND.
- **RESPOND:**
  - rsp.valid = 1 and rsp.ready = 0 for exactly one cycle, then the state returns to IDLE.
- **Writes:**
  - For each lane i with do_write[i] = 1, byte i of the word is set to data[8i+7:8i] on the accept edge.
  - Lanes with do_write[i] = 0 are unchanged.
- **Reads:**
  - The stored word is captured on the accept edge, before any same-request write.
  - rsp.data lane i = captured byte if do_read[i] = 1, else 8'h00.
- **Read and write in one request:** the write is applied and rsp.data returns the old contents.
- **Both masks zero:** the request is treated as a no-op. It still completes with a response, rsp.data = 0, so the initiator cannot hang.
- **Response for writes:** every accepted request produces exactly one rsp.valid pulse, including pure writes. For pure writes, rsp.data = 0.
- **Protocol violation:** req.valid while rsp.ready = 0 is ignored and has no side effects.
- **rsp.data outside RESPOND:** held at 0.

## Timing
- **Reset values:**
  - rsp.valid = 0, rsp.data = 0, state = IDLE, counter = 0, stats counters = 0.
  - rsp.ready = 0 while reset is high and 1 in the first cycle after reset deasserts.
- **Latency:**
  - If a request is accepted at edge k, rsp.valid is high in the cycle after edge k+LATENCY−1 (LATENCY = 1 gives valid in the cycle right after accept).
  - rsp.ready returns high one cycle after that.
- **Throughput:** one request per LATENCY+1 cycles.
- **All outputs are registered.** rsp has no combinational path from req.
- **Reset mid-operation:**
  - A pending response is dropped and no rsp.valid is produced.
  - Writes already committed are retained; memory contents are never cleared by reset.
- **Reset and req.valid in the same cycle:** reset wins and no accept occurs.

## Configuration
- **MEMORY_RESPONDER_STATS_EN defined:**
  - read_count increments on each accept with do_read ≠ 0.
  - write_count increments on each accept with do_write ≠ 0.
  - A request with both masks nonzero increments both counters.
  - Counters wrap at 2^32 and are cleared by reset.
- **MEMORY_RESPONDER_STATS_EN undefined:** both ports and their counters are absent; behaviour is otherwise identical.

## Structure
- **Shared package:**
  - Responder state enum (IDLE/WAIT/RESPOND).
  - Latency counter width constant (4 bits).
  - Lane count constant (4).
  - memory_io_req and memory_io_rsp continue to come from the existing memory_io definitions.
- **Sub-module byte_mask_ram:**
  - DEPTH_WORDS × 32-bit storage with per-byte write enables.
  - Synchronous read whose data reflects pre-write contents on the same edge.
  - The top contains only the FSM, the counter, mask application, response registers, and the optional stats.

## Test plan
- Reset, then hold req idle → rsp.ready = 0 during reset, 1 on the first cycle after, and rsp.valid stays 0.
- Write addr 0x10, data 0xDEADBEEF, do_write 4'b1111, LATENCY = 2 → one rsp.valid pulse 2 cycles after accept. Then read 0x10 with do_read 4'b1111 → rsp.data = 0xDEADBEEF.
- Byte-lane write of data 0x0000AA00, do_write 4'b0010, to the same word → a full read returns 0xDEADAAEF. A read with do_read 4'b0010 returns 0x0000AA00.
- Combined read/write at 0x10 (do_read 4'b1111, do_write 4'b1111, data 0x12345678) → rsp.data = 0xDEADAAEF. A subsequent read returns 0x12345678.
- With DEPTH_WORDS = 16, write 0x40 then read 0x00 → wrap aliasing returns the written value. A request with both masks zero → one response with rsp.data = 0.
- Assert reset in the WAIT state → no rsp.valid, ready = 1 after reset, and prior writes are still readable. With MEMORY_RESPONDER_STATS_EN, 3 reads and 2 writes → read_count = 3, write_count = 2.
